// File: rtl/network_mac_pkg.sv
// ---------------------------------------------------------------------------
// network_mac_pkg
//   Shared constants, the sequencer state encoding and sign-extension helpers
//   for the MAC sequencer that drives the convolution datapath's 16s x 15s
//   multiplier.
// ---------------------------------------------------------------------------
package network_mac_pkg;

    localparam int DIN_W   = 16;              // signed activation width
    localparam int WGT_W   = 15;              // signed weight width
    localparam int PROD_W  = DIN_W + WGT_W;   // multiplier product width (31)
    localparam int ACC_W   = 44;              // accumulator; 4095 max products + bias cannot overflow
    localparam int LEN_W   = 12;              // job length, 0..4095 pairs
    localparam int BIAS_W  = 32;              // signed bias width
    localparam int SHIFT_W = 5;               // right shift, 0..31
    localparam int OUT_W   = 16;              // result activation width

    localparam int SAT_MAX = 32767;
    localparam int SAT_MIN = -32768;

    // Sequencer states; the encoding is visible on the debug state output.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_ROUND = 3'd3,
        ST_OUT   = 3'd4
    } state_e;

    // Sign-extend the job bias to accumulator width.
    function automatic logic [ACC_W-1:0] sext_bias(input logic [BIAS_W-1:0] v);
        return {{(ACC_W-BIAS_W){v[BIAS_W-1]}}, v};
    endfunction

    // Sign-extend a multiplier product to accumulator width.
    function automatic logic [ACC_W-1:0] sext_prod(input logic [PROD_W-1:0] v);
        return {{(ACC_W-PROD_W){v[PROD_W-1]}}, v};
    endfunction

endpackage

// File: rtl/network_mac_round_sat.sv
// ---------------------------------------------------------------------------
// network_mac_round_sat
//   Combinational round-half-up, arithmetic right shift and saturation of the
//   accumulator down to a 16-bit signed activation.
//
//   Ports:
//     acc_i    in   ACC_W    signed accumulated sum
//     shift_i  in   SHIFT_W  arithmetic right-shift amount
//     data_o   out  16       rounded, shifted, clamped result
//     sat_o    out  1        result was clamped to SAT_MIN/SAT_MAX
// ---------------------------------------------------------------------------
module network_mac_round_sat
    import network_mac_pkg::*;
(
    input  logic [ACC_W-1:0]   acc_i,
    input  logic [SHIFT_W-1:0] shift_i,
    output logic [OUT_W-1:0]   data_o,
    output logic               sat_o
);

    // One guard bit so adding the rounding constant can never wrap.
    localparam int XW = ACC_W + 1;
    localparam logic signed [XW-1:0] MAX_X = XW'(SAT_MAX);
    localparam logic signed [XW-1:0] MIN_X = XW'(SAT_MIN);

    logic signed [XW-1:0] acc_x;
    logic signed [XW-1:0] rnd_x;
    logic signed [XW-1:0] sum_x;
    logic signed [XW-1:0] shf_x;

    always_comb begin
        acc_x = {acc_i[ACC_W-1], acc_i};
        rnd_x = '0;
        // Half of one output LSB; a zero shift needs no rounding.
        if (shift_i != '0) begin
            rnd_x = XW'(1) << (shift_i - 1'b1);
        end
        sum_x = acc_x + rnd_x;
        shf_x = sum_x >>> shift_i;

        data_o = shf_x[OUT_W-1:0];
        sat_o  = 1'b0;
        if (shf_x > MAX_X) begin
            data_o = OUT_W'(SAT_MAX);
            sat_o  = 1'b1;
        end else if (shf_x < MIN_X) begin
            data_o = OUT_W'(SAT_MIN);
            sat_o  = 1'b1;
        end
    end

endmodule

// File: rtl/network_mac_seq.sv
// ---------------------------------------------------------------------------
// network_mac_seq
//   Sequencer for the shared signed multiplier. Accepts a job descriptor,
//   streams activation/weight pairs through the external multiplier,
//   accumulates the products onto the bias, then rounds/shifts/saturates the
//   sum and returns it on a valid/ready output.
//
//   Handshakes: every interface uses valid/ready; a transfer happens on the
//   rising edge where both are high. Ready never depends on valid. Outputs
//   are held stable while valid is high and ready is low.
//
//   Ports:
//     ap_clk, ap_rst        clock, synchronous active-high reset
//     cfg_valid/cfg_ready   job descriptor handshake (ready only in IDLE)
//     cfg_len/bias/shift    pairs in job, signed start value, result shift
//     in_valid/in_ready     operand pair handshake (ready only in RUN)
//     in_data/in_wgt        signed activation / weight
//     mul_din0/mul_din1     operands to the external multiplier (0 when idle)
//     mul_dout              combinational product from the multiplier
//     out_valid/out_ready   result handshake
//     out_data/out_sat      saturated result and clamp flag
//     busy                  state is not IDLE
//     dbg_state             current sequencer state encoding
// ---------------------------------------------------------------------------
module network_mac_seq
    import network_mac_pkg::*;
(
    input  logic               ap_clk,
    input  logic               ap_rst,

    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic [BIAS_W-1:0]  cfg_bias,
    input  logic [SHIFT_W-1:0] cfg_shift,

    input  logic               in_valid,
    output logic               in_ready,
    input  logic [DIN_W-1:0]   in_data,
    input  logic [WGT_W-1:0]   in_wgt,

    output logic [DIN_W-1:0]   mul_din0,
    output logic [WGT_W-1:0]   mul_din1,
    input  logic [PROD_W-1:0]  mul_dout,

    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_sat,

    output logic               busy,
    output logic [2:0]         dbg_state
);

    state_e             state_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   prod_q;
    logic               prod_v_q;
    logic [LEN_W-1:0]   cnt_q;
    logic [SHIFT_W-1:0] shift_q;
    logic [OUT_W-1:0]   out_data_q;
    logic               out_sat_q;

    logic               accept;
    logic [OUT_W-1:0]   rs_data;
    logic               rs_sat;

    assign cfg_ready = (state_q == ST_IDLE);
    assign in_ready  = (state_q == ST_RUN);
    assign out_valid = (state_q == ST_OUT);
    assign busy      = (state_q != ST_IDLE);
    assign dbg_state = state_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

    assign accept = in_valid && (state_q == ST_RUN);

    // Operands are zeroed outside an accept so the multiplier stays quiet.
    assign mul_din0 = accept ? in_data : '0;
    assign mul_din1 = accept ? in_wgt  : '0;

    network_mac_round_sat u_round_sat (
        .acc_i   (acc_q),
        .shift_i (shift_q),
        .data_o  (rs_data),
        .sat_o   (rs_sat)
    );

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            prod_q     <= '0;
            prod_v_q   <= 1'b0;
            cnt_q      <= '0;
            shift_q    <= '0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            // Product register: one stage between the multiplier and the adder.
            prod_v_q <= accept;
            if (accept) begin
                prod_q <= sext_prod(mul_dout);
            end

            // Accumulate lags the accept by one cycle; DRAIN covers the last one.
            if (prod_v_q) begin
                acc_q <= acc_q + prod_q;
            end

            case (state_q)
                ST_IDLE: begin
                    if (cfg_valid) begin
                        acc_q   <= sext_bias(cfg_bias);
                        cnt_q   <= cfg_len;
                        shift_q <= cfg_shift;
                        state_q <= (cfg_len != '0) ? ST_RUN : ST_ROUND;
                    end
                end
                ST_RUN: begin
                    if (accept) begin
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == LEN_W'(1)) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    state_q <= ST_ROUND;
                end
                ST_ROUND: begin
                    out_data_q <= rs_data;
                    out_sat_q  <= rs_sat;
                    state_q    <= ST_OUT;
                end
                ST_OUT: begin
                    if (out_ready) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_network_mac_seq.sv
// ---------------------------------------------------------------------------
// tb_network_mac_seq
//   Directed bench for the MAC sequencer with a behavioural multiplier in the
//   parent position. Expected results are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_network_mac_seq;

    logic               ap_clk = 1'b0;
    logic               ap_rst;
    logic               cfg_valid;
    logic               cfg_ready;
    logic [11:0]        cfg_len;
    logic [31:0]        cfg_bias;
    logic [4:0]         cfg_shift;
    logic               in_valid;
    logic               in_ready;
    logic [15:0]        in_data;
    logic [14:0]        in_wgt;
    logic [15:0]        mul_din0;
    logic [14:0]        mul_din1;
    logic [30:0]        mul_dout;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] out_data;
    logic               out_sat;
    logic               busy;
    logic [2:0]         dbg_state;

    int total = 0;
    int bad   = 0;
    int pa[8];
    int pw[8];
    logic [16:0] exp_q[$];   // {sat, data}

    always #5 ap_clk = ~ap_clk;

    // Behavioural stand-in for the external 16s x 15s multiplier.
    assign mul_dout = $signed({{15{mul_din0[15]}}, mul_din0}) *
                      $signed({{16{mul_din1[14]}}, mul_din1});

    network_mac_seq dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_len   (cfg_len),
        .cfg_bias  (cfg_bias),
        .cfg_shift (cfg_shift),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_wgt    (in_wgt),
        .mul_din0  (mul_din0),
        .mul_din1  (mul_din1),
        .mul_dout  (mul_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    task automatic chk(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic cfg_handshake(input string name, input int len, input int bias,
                                 input int shift);
        int n;
        cfg_valid = 1'b1;
        cfg_len   = 12'(len);
        cfg_bias  = 32'(bias);
        cfg_shift = 5'(shift);
        n = 0;
        while (!cfg_ready && n < 50) begin
            step();
            n++;
        end
        chk({name, "_cfg_ready"}, 32'(cfg_ready), 1);
        step();
        cfg_valid = 1'b0;
        chk({name, "_busy"}, 32'(busy), 1);
    endtask

    task automatic send_pair(input string name, input int a, input int w, input bit gap);
        int n;
        if (gap) begin
            in_valid = 1'b0;
            step();
            chk({name, "_stall_in_ready"}, 32'(in_ready), 1);
        end
        in_valid = 1'b1;
        in_data  = 16'(a);
        in_wgt   = 15'(w);
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        chk({name, "_in_ready"}, 32'(in_ready), 1);
        step();
    endtask

    task automatic run_job(input string name, input int len, input int bias,
                           input int shift, input bit gap, input int stall,
                           input int exp_data, input int exp_sat);
        int n;
        bit saw_in;
        logic [16:0] e;
        exp_q.push_back({1'(exp_sat), 16'(exp_data)});
        cfg_handshake(name, len, bias, shift);
        for (int i = 0; i < len; i++) begin
            send_pair(name, pa[i], pw[i], gap);
        end
        in_valid = 1'b0;
        in_data  = '0;
        in_wgt   = '0;
        n = 0;
        saw_in = 1'b0;
        while (!out_valid && n < 20) begin
            if (in_ready) saw_in = 1'b1;
            step();
            n++;
        end
        chk({name, "_latency"}, n, (len == 0) ? 1 : 2);
        chk({name, "_no_in_ready"}, 32'(saw_in), 0);
        chk({name, "_out_valid"}, 32'(out_valid), 1);
        e = exp_q.pop_front();
        chk({name, "_data"}, out_data, $signed(e[15:0]));
        chk({name, "_sat"}, 32'(out_sat), 32'(e[16]));
        for (int s = 0; s < stall; s++) begin
            step();
            chk({name, "_hold_data"}, out_data, $signed(e[15:0]));
            chk({name, "_hold_valid"}, 32'(out_valid), 1);
            chk({name, "_hold_cfg_ready"}, 32'(cfg_ready), 0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({name, "_done_valid"}, 32'(out_valid), 0);
        chk({name, "_done_cfg_ready"}, 32'(cfg_ready), 1);
    endtask

    task automatic chk_reset_state(input string name);
        chk({name, "_cfg_ready"}, 32'(cfg_ready), 1);
        chk({name, "_in_ready"}, 32'(in_ready), 0);
        chk({name, "_out_valid"}, 32'(out_valid), 0);
        chk({name, "_out_data"}, out_data, 0);
        chk({name, "_out_sat"}, 32'(out_sat), 0);
        chk({name, "_busy"}, 32'(busy), 0);
        chk({name, "_state"}, 32'(dbg_state), 0);
    endtask

    initial begin
        ap_rst    = 1'b1;
        cfg_valid = 1'b0;
        cfg_len   = '0;
        cfg_bias  = '0;
        cfg_shift = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_wgt    = '0;
        out_ready = 1'b0;
        repeat (3) step();
        ap_rst = 1'b0;
        chk_reset_state("rst");

        // 6 - 20 - 100 = -114
        pa[0] = 2;   pw[0] = 3;
        pa[1] = -4;  pw[1] = 5;
        pa[2] = 100; pw[2] = -1;
        run_job("basic", 3, 0, 0, 1'b0, 0, -114, 0);

        // 2 * 32767 * 16383 = 1073643522 -> clamp high
        pa[0] = 32767; pw[0] = 16383;
        pa[1] = 32767; pw[1] = 16383;
        run_job("satpos", 2, 0, 0, 1'b0, 0, 32767, 1);

        // -32768 * 16383 = -536838144 -> clamp low
        pa[0] = -32768; pw[0] = 16383;
        run_job("satneg", 1, 0, 0, 1'b0, 0, -32768, 1);

        // (15 + 2) >>> 2 = 4 ; (-15 + 2) >>> 2 = -4
        pa[0] = 5; pw[0] = 3;
        run_job("rndpos", 1, 0, 2, 1'b0, 0, 4, 0);
        pa[0] = -5; pw[0] = 3;
        run_job("rndneg", 1, 0, 2, 1'b0, 0, -4, 0);

        // (1000 + 4) >>> 3 = 125
        run_job("zlen", 0, 1000, 3, 1'b0, 0, 125, 0);

        // -2 + 4 * 1 = 2, gapped input, output held 5 cycles
        for (int i = 0; i < 4; i++) begin
            pa[i] = 1;
            pw[i] = 1;
        end
        run_job("bp", 4, -2, 0, 1'b1, 5, 2, 0);
        pa[0] = 3; pw[0] = 3;
        run_job("bp2", 1, 0, 0, 1'b0, 0, 9, 0);

        // Abort a job after two accepts, with a product in flight.
        cfg_handshake("abort", 4, 0, 0);
        send_pair("abort", 10, 10, 1'b0);
        send_pair("abort", 20, 20, 1'b0);
        in_data  = 16'(30);
        in_wgt   = 15'(30);
        ap_rst   = 1'b1;
        step();
        ap_rst   = 1'b0;
        in_valid = 1'b0;
        chk_reset_state("abort_rst");
        for (int i = 0; i < 5; i++) begin
            step();
            chk("abort_no_out", 32'(out_valid), 0);
        end
        pa[0] = 7; pw[0] = 7;
        run_job("after_rst", 1, 0, 0, 1'b0, 0, 49, 0);

        chk("exp_q_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
